// File: rtl/stream_frame_gen_pkg.sv
// Shared types and defaults for the stream_frame_gen test-pattern source.
package stream_frame_gen_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int LEN_W_DEF  = 16;
  localparam int THR_W_DEF  = 5;

  localparam logic [15:0] HDR_MAGIC = 16'hA5A5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

endpackage

// File: rtl/stream_frame_gen_throttle.sv
// Free-running mod-(i_div+1) counter; o_strobe marks the cycles a new word may be offered.
module stream_frame_gen_throttle #(
  parameter int THR_W = 5
) (
  input  logic             clk,
  input  logic             aresetn,
  input  logic [THR_W-1:0] i_div,
  output logic             o_strobe
);

  logic [THR_W-1:0] r_cnt;

  // ">=" rather than "==" so a divider shrunk mid-run recovers in one cycle
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_cnt <= '0;
    end else if (r_cnt >= i_div) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_strobe = (r_cnt == '0);

endmodule

// File: rtl/stream_frame_gen.sv
// Packetised incrementing-word AXI4-Stream source with gap and valid throttle.
// Optional per-packet sequence header: define STREAM_FRAME_GEN_SEQ_HDR_EN.
module stream_frame_gen
  import stream_frame_gen_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int LEN_W  = LEN_W_DEF,
  parameter int THR_W  = THR_W_DEF
) (
  input  logic              clk,
  input  logic              aresetn,
  input  logic              cfg_enable,
  input  logic [LEN_W-1:0]  cfg_pkt_len,
  input  logic [LEN_W-1:0]  cfg_gap_len,
  input  logic [THR_W-1:0]  cfg_throttle,
  input  logic [DATA_W-1:0] cfg_seed,
  input  logic              cfg_clear,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              busy,
  output logic [31:0]       pkt_count
);

  state_t            r_state, w_state_next;
  logic [LEN_W-1:0]  r_len_m1, r_gap, r_word_idx, r_gap_cnt;
  logic [DATA_W-1:0] r_data;
  logic [31:0]       r_pkt_count;
  logic              r_valid;

  logic w_strobe, w_accept, w_last_word, w_load_cfg, w_clear, w_offer, w_hdr_word;

  stream_frame_gen_throttle #(.THR_W(THR_W)) u_throttle (
    .clk      (clk),
    .aresetn  (aresetn),
    .i_div    (cfg_throttle),
    .o_strobe (w_strobe)
  );

  assign w_accept    = r_valid && m_ready;
  assign w_last_word = (r_word_idx == r_len_m1);

`ifdef STREAM_FRAME_GEN_SEQ_HDR_EN
  // pkt_count only moves on a last-word accept, so at word 0 it still equals the start value
  assign w_hdr_word = (r_word_idx == '0);
  assign m_data     = (r_valid && w_hdr_word) ? DATA_W'({HDR_MAGIC, r_pkt_count[15:0]}) : r_data;
`else
  assign w_hdr_word = 1'b0;
  assign m_data     = r_data;
`endif

  always_comb begin
    w_state_next = r_state;
    w_load_cfg   = 1'b0;
    w_clear      = 1'b0;
    case (r_state)
      IDLE: begin
        w_clear = cfg_clear;
        if (cfg_enable) begin
          w_state_next = SEND;
          w_load_cfg   = 1'b1;
        end
      end
      SEND: begin
        if (w_accept && w_last_word) begin
          if (r_gap != '0) begin
            w_state_next = GAP;
          end else if (cfg_enable) begin
            w_state_next = SEND;
            w_load_cfg   = 1'b1;
          end else begin
            w_state_next = IDLE;
          end
        end
      end
      GAP: begin
        if (r_gap_cnt == r_gap - 1'b1) begin
          if (cfg_enable) begin
            w_state_next = SEND;
            w_load_cfg   = 1'b1;
          end else begin
            w_state_next = IDLE;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Offer on the edge that enters/stays in SEND, so back-to-back packets and gaps have no bubble
  assign w_offer = w_strobe && (w_state_next == SEND) && (!r_valid || w_accept);

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_state     <= IDLE;
      r_len_m1    <= '0;
      r_gap       <= '0;
      r_word_idx  <= '0;
      r_gap_cnt   <= '0;
      r_valid     <= 1'b0;
      r_data      <= '0;
      r_pkt_count <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_load_cfg) begin
        r_len_m1   <= (cfg_pkt_len == '0) ? '0 : cfg_pkt_len - 1'b1;
        r_gap      <= cfg_gap_len;
        r_word_idx <= '0;
      end else if (w_accept) begin
        r_word_idx <= r_word_idx + 1'b1;
      end
      r_gap_cnt <= (r_state == GAP) ? r_gap_cnt + 1'b1 : '0;
      if (w_offer) begin
        r_valid <= 1'b1;
      end else if (w_accept) begin
        r_valid <= 1'b0;
      end
      if (w_clear) begin
        r_data <= cfg_seed;
      end else if (w_accept && !w_hdr_word) begin
        r_data <= r_data + 1'b1;
      end
      if (w_clear) begin
        r_pkt_count <= '0;
      end else if (w_accept && w_last_word) begin
        r_pkt_count <= r_pkt_count + 1'b1;
      end
    end
  end

  assign m_valid   = r_valid;
  assign m_last    = r_valid && w_last_word;
  assign busy      = (r_state != IDLE);
  assign pkt_count = r_pkt_count;

endmodule

// File: tb/tb_stream_frame_gen.sv
// Scoreboard bench for stream_frame_gen: directed packets, stalls, throttle, enable drop, reset.
module tb_stream_frame_gen;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } exp_t;

  logic        clk = 1'b0;
  logic        aresetn, cfg_enable, cfg_clear, m_ready, m_valid, m_last, busy;
  logic [15:0] cfg_pkt_len, cfg_gap_len;
  logic [4:0]  cfg_throttle;
  logic [31:0] cfg_seed, m_data, pkt_count;

  exp_t        exp_q[$];
  int          acc_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  bit          rnd_ready = 1'b0;
  logic [31:0] mdl_data, mdl_pc;

  always #5 clk = ~clk;

  stream_frame_gen dut (
    .clk          (clk),
    .aresetn      (aresetn),
    .cfg_enable   (cfg_enable),
    .cfg_pkt_len  (cfg_pkt_len),
    .cfg_gap_len  (cfg_gap_len),
    .cfg_throttle (cfg_throttle),
    .cfg_seed     (cfg_seed),
    .cfg_clear    (cfg_clear),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .m_last       (m_last),
    .busy         (busy),
    .pkt_count    (pkt_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  task automatic push_pkt(input int len);
    exp_t e;
    for (int i = 0; i < len; i++) begin
`ifdef STREAM_FRAME_GEN_SEQ_HDR_EN
      if (i == 0) begin
        e.data = {16'hA5A5, mdl_pc[15:0]};
      end else begin
        e.data   = mdl_data;
        mdl_data = mdl_data + 32'd1;
      end
`else
      e.data   = mdl_data;
      mdl_data = mdl_data + 32'd1;
`endif
      e.last = (i == len - 1);
      exp_q.push_back(e);
    end
    mdl_pc = mdl_pc + 32'd1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (!busy && !m_valid) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    check("idle_reached", {31'b0, ok}, 32'd1);
  endtask

  // Enable until the n-th packet has begun, then drop enable and let it finish
  task automatic run_pkts(input int n, input bit clr);
    int base;
    bit ok = 1'b0;
    base = clr ? 0 : int'(pkt_count);
    cfg_clear  = clr;
    cfg_enable = 1'b1;
    step();
    cfg_clear = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (pkt_count == 32'(base + n - 1) && m_valid) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    check("last_pkt_started", {31'b0, ok}, 32'd1);
    cfg_enable = 1'b0;
    wait_idle();
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: pops the scoreboard on every handshake, checks hold during stalls
  initial begin
    exp_t        e;
    logic        stall_prev = 1'b0;
    logic [31:0] sd = '0;
    logic        sl = 1'b0;
    forever begin
      @(negedge clk);
      if (aresetn) begin
        if (stall_prev) begin
          check("hold_valid", {31'b0, m_valid}, 32'd1);
          check("hold_data", m_data, sd);
          check("hold_last", {31'b0, m_last}, {31'b0, sl});
        end
        if (m_valid && m_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_word: got 0x%08h, expected no word", m_data);
          end else begin
            e = exp_q.pop_front();
            $display("cycle %0d: word 0x%08h last=%0b (expect 0x%08h last=%0b)",
                     cyc, m_data, m_last, e.data, e.last);
            check("word_data", m_data, e.data);
            check("word_last", {31'b0, m_last}, {31'b0, e.last});
          end
          acc_q.push_back(cyc);
        end
        stall_prev = m_valid && !m_ready;
        sd = m_data;
        sl = m_last;
      end else begin
        stall_prev = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected test completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  a;
    bit  ok;
    aresetn      = 1'b0;
    cfg_enable   = 1'b0;
    cfg_clear    = 1'b0;
    cfg_pkt_len  = 16'd4;
    cfg_gap_len  = 16'd0;
    cfg_throttle = 5'd0;
    cfg_seed     = 32'h0000_1C50;
    mdl_data     = '0;
    mdl_pc       = '0;
    repeat (3) step();
    check("rst_valid", {31'b0, m_valid}, 32'd0);
    check("rst_last", {31'b0, m_last}, 32'd0);
    check("rst_data", m_data, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_pkt_count", pkt_count, 32'd0);
    aresetn = 1'b1;
    step();

    // 1: two back-to-back packets of 4 from seed 0x1C50
    mdl_data = 32'h0000_1C50;
    mdl_pc   = '0;
    push_pkt(4);
    push_pkt(4);
    a = acc_q.size();
    run_pkts(2, 1'b1);
    check("t1_pkt_count", pkt_count, 32'd2);
    check("t1_back_to_back", 32'(acc_q[a+7] - acc_q[a]), 32'd7);

    // 2: len 3 with a 5-cycle gap
    cfg_pkt_len = 16'd3;
    cfg_gap_len = 16'd5;
    push_pkt(3);
    push_pkt(3);
    a = acc_q.size();
    run_pkts(2, 1'b0);
    check("t2_in_pkt_spacing", 32'(acc_q[a+1] - acc_q[a]), 32'd1);
    check("t2_gap_spacing", 32'(acc_q[a+3] - acc_q[a+2]), 32'd6);
    check("t2_pkt_count", pkt_count, 32'd4);

    // 3: random ready stalls
    cfg_pkt_len = 16'd5;
    cfg_gap_len = 16'd1;
    rnd_ready   = 1'b1;
    push_pkt(5);
    push_pkt(5);
    run_pkts(2, 1'b0);
    rnd_ready = 1'b0;
    step();
    check("t3_pkt_count", pkt_count, 32'd6);

    // 4: throttle 3 -> one word every 4 cycles
    cfg_pkt_len  = 16'd8;
    cfg_gap_len  = 16'd0;
    cfg_throttle = 5'd3;
    push_pkt(8);
    a = acc_q.size();
    run_pkts(1, 1'b0);
    for (int i = 0; i < 7; i++) begin
      check("t4_throttle_spacing", 32'(acc_q[a+i+1] - acc_q[a+i]), 32'd4);
    end
    check("t4_span_ok", {31'b0, (acc_q[a+7] - acc_q[a]) >= 28}, 32'd1);
    cfg_throttle = 5'd0;

    // 5: enable dropped right after the packet starts; all 6 words still sent
    cfg_pkt_len = 16'd6;
    push_pkt(6);
    run_pkts(1, 1'b0);
    check("t5_busy", {31'b0, busy}, 32'd0);
    check("t5_pkt_count", pkt_count, 32'd8);

    // 6: data wrap from 0xFFFFFFFE, then reset in mid-packet
    cfg_pkt_len = 16'd4;
    cfg_seed    = 32'hFFFF_FFFE;
    mdl_data    = 32'hFFFF_FFFE;
    mdl_pc      = '0;
    push_pkt(4);
    run_pkts(1, 1'b1);
    check("t6_pkt_count", pkt_count, 32'd1);

    push_pkt(4);
    a = acc_q.size();
    cfg_enable = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (acc_q.size() >= a + 2) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    check("t6_two_words_before_reset", {31'b0, ok}, 32'd1);
    aresetn = 1'b0;
    #1;
    check("t6_rst_valid", {31'b0, m_valid}, 32'd0);
    check("t6_rst_last", {31'b0, m_last}, 32'd0);
    check("t6_rst_data", m_data, 32'd0);
    check("t6_rst_busy", {31'b0, busy}, 32'd0);
    check("t6_rst_pkt_count", pkt_count, 32'd0);
    exp_q.delete();
    cfg_enable = 1'b0;
    step();
    aresetn  = 1'b1;
    mdl_data = '0;
    mdl_pc   = '0;
    cfg_pkt_len = 16'd2;
    push_pkt(2);
    run_pkts(1, 1'b0);
    check("t6_post_reset_pkt_count", pkt_count, 32'd1);

    repeat (3) step();
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
